binar_thr_ctrl: RTL and testbench

//  Frame-synchronous threshold controller for the Y-binarization stage after RGB->YCbCr.

---
 rtl/binar_thr_ctrl.sv | 167 ++++++++++++++++
 tb/tb_binar_thr_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/binar_thr_ctrl.sv
// Frame-synchronous binarization threshold controller: manual key stepping or
// auto mode from the previous frame's mean luma, applied only at frame boundaries.
module binar_thr_ctrl #(
    parameter logic [7:0]        DEFAULT_THR = 8'd128,
    parameter logic [7:0]        STEP        = 8'd4,
    parameter logic signed [8:0] AUTO_OFS    = 9'sd0,
    parameter int unsigned       SUM_W       = 27,
    parameter int unsigned       CNT_W       = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ycbcr_vsync,
    input  logic       ycbcr_de,
    input  logic [7:0] img_y,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_down,
    output logic [7:0] threshold,
    output logic       auto_mode,
    output logic       thr_update,
    output logic       busy
);

    localparam int unsigned BIT_W = $clog2(SUM_W + 1);

    typedef enum logic [1:0] {StIdle, StDiv, StApply} state_t;

    state_t             state_q, state_d;
    logic               vs_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0]   dvd_q, dvd_d;
    logic [CNT_W-1:0]   dvs_q, dvs_d;
    logic [CNT_W:0]     rem_q, rem_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [7:0]         thr_q, thr_d;
    logic [7:0]         pending_q, pending_d;
    logic               auto_q, auto_d;
    logic               upd_q, upd_d;
    logic               busy_q, busy_d;

    logic               frame_end;
    logic [CNT_W:0]     rem_sh;
    logic               rem_ge;
    logic [8:0]         up_sum;
    logic [7:0]         q8;
    logic signed [9:0]  ofs_sum;
    logic [7:0]         auto_thr;

    assign frame_end = ycbcr_vsync & ~vs_d;

    // Restoring divider step: dvd_q shifts out dividend bits and shifts in quotient bits
    assign rem_sh = {rem_q[CNT_W-1:0], dvd_q[SUM_W-1]};
    assign rem_ge = rem_sh >= {1'b0, dvs_q};

    assign up_sum   = {1'b0, pending_q} + {1'b0, STEP};
    assign q8       = (|dvd_q[SUM_W-1:8]) ? 8'hff : dvd_q[7:0];
    assign ofs_sum  = $signed({2'b00, q8}) + $signed({AUTO_OFS[8], AUTO_OFS});
    assign auto_thr = (ofs_sum < 0) ? 8'd0 : ((ofs_sum > 10'sd255) ? 8'hff : ofs_sum[7:0]);

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (frame_end) begin
            sum_d = ycbcr_de ? SUM_W'(img_y) : '0;
            cnt_d = ycbcr_de ? CNT_W'(1) : '0;
        end else if (ycbcr_de && !(&cnt_q)) begin
            sum_d = sum_q + SUM_W'(img_y);
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        auto_d    = auto_q ^ key_mode;
        pending_d = pending_q;
        if (key_mode && auto_q) begin
            pending_d = thr_q;
        end else if (!auto_q && (key_up ^ key_down)) begin
            if (key_up) begin
                pending_d = up_sum[8] ? 8'hff : up_sum[7:0];
            end else begin
                pending_d = (pending_q < STEP) ? 8'd0 : pending_q - STEP;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        upd_d   = 1'b0;
        thr_d   = thr_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        bit_d   = bit_q;
        unique case (state_q)
            StIdle: begin
                if (frame_end) begin
                    if (!auto_q) begin
                        thr_d = pending_q;
                        upd_d = 1'b1;
                    end else if (cnt_q != '0) begin
                        state_d = StDiv;
                        busy_d  = 1'b1;
                        dvd_d   = sum_q;
                        dvs_d   = cnt_q;
                        rem_d   = '0;
                        bit_d   = BIT_W'(SUM_W);
                    end
                end
            end
            StDiv: begin
                dvd_d = {dvd_q[SUM_W-2:0], rem_ge};
                rem_d = rem_ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
                bit_d = bit_q - BIT_W'(1);
                if (bit_q == BIT_W'(1)) begin
                    state_d = StApply;
                    busy_d  = 1'b0;
                end
            end
            StApply: begin
                thr_d   = auto_thr;
                upd_d   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            vs_d      <= 1'b0;
            sum_q     <= '0;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            bit_q     <= '0;
            thr_q     <= DEFAULT_THR;
            pending_q <= DEFAULT_THR;
            auto_q    <= 1'b0;
            upd_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vs_d      <= ycbcr_vsync;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            bit_q     <= bit_d;
            thr_q     <= thr_d;
            pending_q <= pending_d;
            auto_q    <= auto_d;
            upd_q     <= upd_d;
            busy_q    <= busy_d;
        end
    end

    assign threshold  = thr_q;
    assign auto_mode  = auto_q;
    assign thr_update = upd_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_binar_thr_ctrl.sv
// Directed bench for binar_thr_ctrl; three instances differ only in AUTO_OFS (0, +200, -200).
module tb_binar_thr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ycbcr_vsync, ycbcr_de, key_mode, key_up, key_down;
    logic [7:0] img_y;
    logic [7:0] thr0, thr1, thr2;
    logic       am0, am1, am2, upd0, upd1, upd2, busy0, busy1, busy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    binar_thr_ctrl #(.AUTO_OFS(9'sd0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ycbcr_vsync(ycbcr_vsync), .ycbcr_de(ycbcr_de),
        .img_y(img_y), .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
        .threshold(thr0), .auto_mode(am0), .thr_update(upd0), .busy(busy0)
    );
    binar_thr_ctrl #(.AUTO_OFS(9'sd200)) dut1 (
        .clk(clk), .rst_n(rst_n), .ycbcr_vsync(ycbcr_vsync), .ycbcr_de(ycbcr_de),
        .img_y(img_y), .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
        .threshold(thr1), .auto_mode(am1), .thr_update(upd1), .busy(busy1)
    );
    binar_thr_ctrl #(.AUTO_OFS(-9'sd200)) dut2 (
        .clk(clk), .rst_n(rst_n), .ycbcr_vsync(ycbcr_vsync), .ycbcr_de(ycbcr_de),
        .img_y(img_y), .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
        .threshold(thr2), .auto_mode(am2), .thr_update(upd2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_up();
        key_up = 1'b1; tick(); key_up = 1'b0; tick();
    endtask

    task automatic pulse_down();
        key_down = 1'b1; tick(); key_down = 1'b0; tick();
    endtask

    task automatic pulse_mode();
        key_mode = 1'b1; tick(); key_mode = 1'b0; tick();
    endtask

    // Raises vsync and returns just after edge E
    task automatic frame_edge();
        ycbcr_vsync = 1'b1;
        tick();
    endtask

    task automatic vsync_low();
        repeat (3) tick();
        ycbcr_vsync = 1'b0;
        tick();
    endtask

    int  cnt;
    int  guard;
    bit  seen;

    initial begin
        rst_n = 1'b0; ycbcr_vsync = 1'b0; ycbcr_de = 1'b0; img_y = 8'd0;
        key_mode = 1'b0; key_up = 1'b0; key_down = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("reset_thr", thr0, 128);
        check("reset_auto", am0, 0);
        check("reset_busy", busy0, 0);
        check("reset_upd", upd0, 0);

        // 1: manual steps take effect only at E
        repeat (3) pulse_up();
        check("man_hold", thr0, 128);
        check("man_upd_idle", upd0, 0);
        frame_edge();
        check("man_apply", thr0, 140);
        check("man_upd_pulse", upd0, 1);
        tick();
        check("man_upd_end", upd0, 0);
        vsync_low();

        // 2: saturation and simultaneous keys
        repeat (40) pulse_up();
        frame_edge();
        check("sat_high", thr0, 255);
        vsync_low();
        repeat (70) pulse_down();
        frame_edge();
        check("sat_low", thr0, 0);
        vsync_low();
        pulse_up();
        key_up = 1'b1; key_down = 1'b1; tick();
        key_up = 1'b0; key_down = 1'b0; tick();
        frame_edge();
        check("up_down_same", thr0, 4);
        vsync_low();

        // 3: auto, 16 pixels of Y=100
        pulse_mode();
        check("auto_on", am0, 1);
        ycbcr_de = 1'b1; img_y = 8'd100;
        repeat (16) tick();
        ycbcr_de = 1'b0;
        tick();
        frame_edge();
        check("div_busy_start", busy0, 1);
        check("div_thr_held", thr0, 4);
        cnt = 0; guard = 0;
        while (busy0 === 1'b1 && guard < 100) begin
            cnt++;
            tick();
            guard++;
        end
        check("busy_cycles", cnt, 27);
        check("pre_apply_thr", thr0, 4);
        check("pre_apply_upd", upd0, 0);
        tick();
        check("auto_100", thr0, 100);
        check("auto_upd", upd0, 1);
        check("auto_100_ofs_pos", thr1, 255);
        check("auto_100_ofs_neg", thr2, 0);
        tick();
        check("auto_upd_end", upd0, 0);
        vsync_low();

        // 4: alternating 0/255, mean 127
        for (int i = 0; i < 8; i++) begin
            ycbcr_de = 1'b1;
            img_y = (i % 2 == 1) ? 8'd255 : 8'd0;
            tick();
        end
        ycbcr_de = 1'b0;
        tick();
        frame_edge();
        repeat (28) tick();
        check("mean_127", thr0, 127);
        check("mean_ofs_pos_sat", thr1, 255);
        check("mean_ofs_neg_sat", thr2, 0);
        vsync_low();

        // 5: auto frame with no active pixels
        repeat (10) tick();
        frame_edge();
        check("empty_busy", busy0, 0);
        check("empty_upd", upd0, 0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (upd0 !== 1'b0 || busy0 !== 1'b0) seen = 1'b1;
            tick();
        end
        check("empty_quiet", seen, 0);
        check("empty_thr", thr0, 127);
        vsync_low();

        // 6: reset in the middle of a divide
        ycbcr_de = 1'b1; img_y = 8'd50;
        repeat (4) tick();
        ycbcr_de = 1'b0;
        tick();
        frame_edge();
        repeat (5) tick();
        check("mid_div_busy", busy0, 1);
        rst_n = 1'b0;
        #1;
        check("rst_thr", thr0, 128);
        check("rst_auto", am0, 0);
        check("rst_busy", busy0, 0);
        check("rst_upd", upd0, 0);
        ycbcr_vsync = 1'b0;
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (upd0 !== 1'b0) seen = 1'b1;
            tick();
        end
        check("rst_no_apply", seen, 0);
        check("rst_thr_kept", thr0, 128);
        pulse_down();
        frame_edge();
        check("post_rst_manual", thr0, 124);
        check("post_rst_upd", upd0, 1);
        vsync_low();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
